ss_mapper_seq: RTL
==================

# ss_mapper_seq

Save-state sequencer sitting directly upstream of the mapper save-state port (`ss_act`/`ss_we`/`ss_addr`/`ss_rdat`). On request it either dumps the mapper's register file (slots 0..REG_COUNT-1, then the map-index byte at address 127) into a byte-wide snapshot buffer, or restores it from that buffer after verifying the map index. Runs on the system clock; the mapper samples on negedge `m2`, so every write strobe is held long enough to span a full `m2` period.

## Interface
- REG_COUNT, 16, mapper register bytes sequenced (ss_addr 0..REG_COUNT-1)
- IDX_ADDR, 127, ss_addr of the read-only map-index byte
- HOLD, 32, clk cycles `ss_we` stays high per byte (≥ one m2 period + margin)
- SETTLE, 2, clk cycles between ss_addr change and ss_rdat sample / ss_we rise
- clk  in  1  system clock; everything on rising edge
- rst_n  in  1  synchronous active-low reset
- start_save  in  1  one-cycle request: dump mapper → buffer
- start_load  in  1  one-cycle request: buffer → mapper
- ss_act  out  1  save-state mode to mapper (gates normal register writes)
- ss_we  out  1  save-state write strobe to mapper
- ss_addr  out  8  save-state register address
- ss_wdat  out  8  data driven on cpu_dat path during restore
- ss_rdat  in  8  mapper readback, combinational from ss_addr
- mem_addr  out  5  buffer slot (0..REG_COUNT-1 registers, REG_COUNT = map index)
- mem_wdat  out  8  buffer write data
- mem_we  out  1  1 = write request, 0 = read request
- mem_req  out  1  buffer request, held until mem_ack
- mem_ack  in  1  one-cycle acknowledge; mem_rdat valid in the ack cycle for reads
- mem_rdat  in  8  buffer read data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end (success or error)
- err  out  1  sticky map-index mismatch on last load; cleared by next start

## Operation
- States: IDLE, SV_ADDR, SV_MEM, LD_IDX_MEM, LD_IDX_CHK, LD_MEM, LD_STROBE, LD_GAP, FIN.
- IDLE: start_save → SV_ADDR with slot 0, err←0. start_load → LD_IDX_MEM, err←0. Both same cycle: save wins. Starts while busy ignored.
- Slot→ss_addr: slot<REG_COUNT → slot; slot==REG_COUNT → IDX_ADDR.
- SV_ADDR: drive ss_addr, wait SETTLE cycles, latch ss_rdat into mem_wdat → SV_MEM.
- SV_MEM: mem_req=1, mem_we=1, mem_addr=slot until mem_ack. After ack: slot<REG_COUNT → slot+1, SV_ADDR; else FIN.
- LD_IDX_MEM: read buffer slot REG_COUNT; on ack capture byte → LD_IDX_CHK.
- LD_IDX_CHK: ss_addr=IDX_ADDR, wait SETTLE, compare captured byte to ss_rdat. Mismatch → err←1, FIN, no mapper write. Match → slot 0, LD_MEM.
- LD_MEM: read buffer slot; on ack ss_wdat←mem_rdat, ss_addr←slot → LD_STROBE.
- LD_STROBE: SETTLE cycles ss_we=0, then ss_we=1 for HOLD cycles → LD_GAP.
- LD_GAP: ss_we=0 for SETTLE cycles, ss_addr/ss_wdat unchanged. slot<REG_COUNT-1 → slot+1, LD_MEM; else FIN. Map-index slot is never written.
- FIN: done=1 one cycle, ss_act=0 → IDLE.
- ss_act=1 in every state except IDLE and FIN.

## Timing
- Reset values: ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdat=0, busy=0, done=0, err=0, state IDLE.
- busy rises the cycle after start, falls with done.
- ss_addr/ss_wdat never change while ss_we=1; ss_we low ≥ SETTLE cycles around each addr change.
- mem_req/mem_we/mem_addr/mem_wdat stable from request until ack cycle inclusive; mem_req drops the cycle after ack.
- Save with zero-wait ack: per slot SETTLE+2 cycles; total (REG_COUNT+1)(SETTLE+2)+2.
- Load, per register slot: mem wait + 2·SETTLE + HOLD + 1.
- Reset mid-sequence: next edge all outputs to reset values; partial restore is not undone; no done pulse.
- mem_ack while mem_req=0 ignored.

## Test plan
- Save: mapper model regs = 0x10+i, map_idx 18; start_save, ack 1 cycle later → buffer slots 0..15 = 0x10..0x1F, slot 16 = 18, one done, err=0.
- Load: buffer slots 0..15 = 0xA0+i, slot 16 = 18, map_idx 18 → mapper regs = 0xA0+i, ss_we high exactly 32 cycles per byte, 16 strobes, err=0.
- Index mismatch: buffer slot 16 = 4, map_idx 18 → err=1, done pulse, zero ss_we pulses, regs unchanged.
- Handshake stall: mem_ack delayed 0..7 random cycles → identical results; mem_req/mem_addr stable throughout.
- Simultaneous start_save+start_load in IDLE → save runs; start_load during busy ignored (single done).
- rst_n low during LD_STROBE of slot 5 → next cycle ss_we=0, ss_act=0, busy=0; regs 0..4 restored, 6..15 untouched.

Source files
------------

// File: rtl/ss_mapper_seq_if.sv
// Snapshot-buffer request/acknowledge bus between the save-state
// sequencer (master) and the byte-wide snapshot memory (slave).
interface ss_mapper_seq_if;
   logic       mem_req;
   logic       mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdat;
   logic       mem_ack;
   logic [7:0] mem_rdat;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdat,
      input  mem_ack, mem_rdat
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdat,
      output mem_ack, mem_rdat
   );
endinterface

// File: rtl/ss_mapper_seq.sv
// Save-state sequencer: dumps the mapper register file to a snapshot
// buffer, or restores it after checking the stored map index.
module ss_mapper_seq #(
   parameter int REG_COUNT = 16,
   parameter int IDX_ADDR  = 127,
   parameter int HOLD      = 32,
   parameter int SETTLE    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_save,
   input  logic       start_load,
   output logic       ss_act,
   output logic       ss_we,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   ss_mapper_seq_if.master mem,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int CW = 7;

   typedef enum logic [3:0] {
      IDLE, SV_ADDR, SV_MEM, LD_IDX_MEM, LD_IDX_CHK,
      LD_MEM, LD_STROBE, LD_GAP, FIN
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [4:0]    slot;
   logic [7:0]    idx_byte;
   logic [7:0]    wdat_r;

   logic settle_end;
   logic strobe_end;
   logic last_reg;
   logic idx_slot;

   assign settle_end = (cnt == CW'(SETTLE - 1));
   assign strobe_end = (cnt == CW'(SETTLE + HOLD - 1));
   assign last_reg   = (slot == 5'(REG_COUNT - 1));
   assign idx_slot   = (slot == 5'(REG_COUNT));

   // The map-index byte lives outside the contiguous register range.
   function automatic logic [7:0] slot_addr(input logic [4:0] s);
      return (int'(s) < REG_COUNT) ? 8'(s) : 8'(IDX_ADDR);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         slot     <= '0;
         idx_byte <= '0;
         wdat_r   <= '0;
         ss_addr  <= '0;
         ss_wdat  <= '0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
         unique case (state)
            IDLE: begin
               if (start_save) begin
                  slot    <= '0;
                  ss_addr <= slot_addr(5'd0);
                  err     <= 1'b0;
               end else if (start_load) begin
                  slot <= 5'(REG_COUNT);
                  err  <= 1'b0;
               end
            end
            SV_ADDR: begin
               if (settle_end) wdat_r <= ss_rdat;
            end
            SV_MEM: begin
               if (mem.mem_ack && !idx_slot) begin
                  slot    <= slot + 1'b1;
                  ss_addr <= slot_addr(slot + 1'b1);
               end
            end
            LD_IDX_MEM: begin
               if (mem.mem_ack) begin
                  idx_byte <= mem.mem_rdat;
                  ss_addr  <= 8'(IDX_ADDR);
               end
            end
            LD_IDX_CHK: begin
               if (settle_end) begin
                  if (idx_byte != ss_rdat) err <= 1'b1;
                  else slot <= '0;
               end
            end
            LD_MEM: begin
               if (mem.mem_ack) begin
                  ss_wdat <= mem.mem_rdat;
                  ss_addr <= slot_addr(slot);
               end
            end
            LD_GAP: begin
               if (settle_end && !last_reg) slot <= slot + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start_save)      state_nxt = SV_ADDR;
            else if (start_load) state_nxt = LD_IDX_MEM;
         end
         SV_ADDR: begin
            if (settle_end) state_nxt = SV_MEM;
         end
         SV_MEM: begin
            if (mem.mem_ack) state_nxt = idx_slot ? FIN : SV_ADDR;
         end
         LD_IDX_MEM: begin
            if (mem.mem_ack) state_nxt = LD_IDX_CHK;
         end
         LD_IDX_CHK: begin
            if (settle_end)
               state_nxt = (idx_byte == ss_rdat) ? LD_MEM : FIN;
         end
         LD_MEM: begin
            if (mem.mem_ack) state_nxt = LD_STROBE;
         end
         LD_STROBE: begin
            if (strobe_end) state_nxt = LD_GAP;
         end
         LD_GAP: begin
            if (settle_end) state_nxt = last_reg ? FIN : LD_MEM;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ss_act       = (state != IDLE) && (state != FIN);
      busy         = ss_act;
      done         = (state == FIN);
      ss_we        = (state == LD_STROBE) && (cnt >= CW'(SETTLE));
      mem.mem_req  = (state == SV_MEM) || (state == LD_IDX_MEM) ||
                     (state == LD_MEM);
      mem.mem_we   = (state == SV_MEM);
      mem.mem_addr = slot;
      mem.mem_wdat = wdat_r;
   end

endmodule
